// File: rtl/ripple_count_checker_if.sv
// ripple_count_checker_if
// Groups the enable/count stimulus and the status outputs of the ripple
// counter checker. The master side drives the counter sample, the slave side
// is the checker itself.
interface ripple_count_checker_if #(
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 8
);
    logic              ENABLE;
    logic [3:0]        COUNT_IN;
    logic              LOCKED;
    logic              ERROR;
    logic [ERR_W-1:0]  ERR_COUNT;
    logic [WRAP_W-1:0] WRAP_COUNT;
    logic [1:0]        STATE;

    modport master (
        output ENABLE,
        output COUNT_IN,
        input  LOCKED,
        input  ERROR,
        input  ERR_COUNT,
        input  WRAP_COUNT,
        input  STATE
    );

    modport slave (
        input  ENABLE,
        input  COUNT_IN,
        output LOCKED,
        output ERROR,
        output ERR_COUNT,
        output WRAP_COUNT,
        output STATE
    );
endinterface

// File: rtl/ripple_count_checker.sv
// ripple_count_checker
// Watches the output of a 4-bit mod-16 ripple counter, checks that every
// sample is the mod-16 successor (or predecessor when DOWN=1) of the previous
// one, locks after LOCK_LEN correct steps, and counts step errors and wraps.
// Optional feature: define RCC_HOLD_TOLERANCE_EN to treat a repeated value as
// a legal hold instead of a step error.
module ripple_count_checker #(
    parameter bit DOWN     = 1'b0,
    parameter int LOCK_LEN = 4,
    parameter int ERR_W    = 8,
    parameter int WRAP_W   = 8
) (
    input  logic                  CLOCK,
    input  logic                  CLEAR,
    ripple_count_checker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACQUIRE = 2'b01,
        LOCK    = 2'b10
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [3:0]        prev;
    logic [3:0]        prev_next;
    logic [3:0]        good;
    logic [3:0]        good_next;
    logic              error_reg;
    logic              error_next;
    logic              locked_reg;
    logic [ERR_W-1:0]  err_count;
    logic [ERR_W-1:0]  err_count_next;
    logic [WRAP_W-1:0] wrap_count;
    logic [WRAP_W-1:0] wrap_count_next;

    logic [3:0]        expected;
    logic [4:0]        good_inc;
    logic              step_match;
    logic              step_hold;
    logic              step_wrap;
    logic              lock_hit;

    // Step classification: expected successor, match, hold, wrap and lock threshold
    always_comb begin
        expected   = DOWN ? (prev - 4'd1) : (prev + 4'd1);
        step_match = (bus.COUNT_IN == expected);
`ifdef RCC_HOLD_TOLERANCE_EN
        step_hold  = (bus.COUNT_IN == prev);
`else
        step_hold  = 1'b0;
`endif
        step_wrap  = step_match && (DOWN ? (prev == 4'd0) : (prev == 4'd15));
        good_inc   = {1'b0, good} + 5'd1;
        lock_hit   = (good_inc == 5'(LOCK_LEN));
    end

    // State register; CLEAR wins over every other condition
    always_ff @(posedge CLOCK) begin
        if (CLEAR) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: ENABLE low always falls back to IDLE
    always_comb begin
        state_next = state;
        if (!bus.ENABLE) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_next = ACQUIRE;
                end
                ACQUIRE: begin
                    if (!step_hold && step_match && lock_hit) begin
                        state_next = LOCK;
                    end
                end
                LOCK: begin
                    if (!step_hold && !step_match) begin
                        state_next = ACQUIRE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Output/datapath next values: sample tracking, run length, error pulse, saturating counters
    always_comb begin
        prev_next       = prev;
        good_next       = good;
        error_next      = 1'b0;
        err_count_next  = err_count;
        wrap_count_next = wrap_count;
        if (bus.ENABLE) begin
            case (state)
                IDLE: begin
                    prev_next = bus.COUNT_IN;
                    good_next = 4'd0;
                end
                ACQUIRE: begin
                    prev_next = bus.COUNT_IN;
                    if (!step_hold) begin
                        if (step_match) begin
                            good_next = good_inc[3:0];
                            if (step_wrap && (wrap_count != '1)) begin
                                wrap_count_next = wrap_count + WRAP_W'(1);
                            end
                        end else begin
                            good_next = 4'd0;
                        end
                    end
                end
                LOCK: begin
                    prev_next = bus.COUNT_IN;
                    if (!step_hold) begin
                        if (step_match) begin
                            if (step_wrap && (wrap_count != '1)) begin
                                wrap_count_next = wrap_count + WRAP_W'(1);
                            end
                        end else begin
                            error_next = 1'b1;
                            good_next  = 4'd0;
                            if (err_count != '1) begin
                                err_count_next = err_count + ERR_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    prev_next = prev;
                end
            endcase
        end
    end

    // Datapath and output registers, all cleared synchronously
    always_ff @(posedge CLOCK) begin
        if (CLEAR) begin
            prev       <= 4'd0;
            good       <= 4'd0;
            error_reg  <= 1'b0;
            locked_reg <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
        end else begin
            prev       <= prev_next;
            good       <= good_next;
            error_reg  <= error_next;
            locked_reg <= (state_next == LOCK);
            err_count  <= err_count_next;
            wrap_count <= wrap_count_next;
        end
    end

    assign bus.STATE      = state;
    assign bus.LOCKED     = locked_reg;
    assign bus.ERROR      = error_reg;
    assign bus.ERR_COUNT  = err_count;
    assign bus.WRAP_COUNT = wrap_count;

endmodule
